// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if: request/response handshake bundle for the two requesters of shifter_arbiter
// master: requester side (drives req*, rsp*_ready); slave: arbiter side (drives req*_ready, rsp*_valid/data)
interface shifter_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready, req0_dir, req0_arith;
  logic [WIDTH-1:0] req0_data;
  logic [4:0]       req0_amount;
  logic             req1_valid, req1_ready, req1_dir, req1_arith;
  logic [WIDTH-1:0] req1_data;
  logic [4:0]       req1_amount;
  logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  modport master (
    output req0_valid, req0_data, req0_amount, req0_dir, req0_arith,
    output req1_valid, req1_data, req1_amount, req1_dir, req1_arith,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready
  );
  modport slave (
    input  req0_valid, req0_data, req0_amount, req0_dir, req0_arith,
    input  req1_valid, req1_data, req1_amount, req1_dir, req1_arith,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter: round-robin sharing of one external combinational barrel shifter between two requesters
// Ports: clk, rst_n (async active-low); bus (shifter_arbiter_if.slave) requester handshakes;
//   sh_data_in_o/sh_amount_o/sh_direction_o drive the shared shifter, sh_data_out_i is its result;
//   busy_o high whenever a transaction is in flight.
// Optional: define SHIFTER_ARB_SRA_EN to add a MASK pass that sign-fills arithmetic right shifts.
module shifter_arbiter #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  shifter_arbiter_if.slave bus,
  output logic [WIDTH-1:0] sh_data_in_o,
  output logic [4:0]       sh_amount_o,
  output logic             sh_direction_o,
  input  logic [WIDTH-1:0] sh_data_out_i,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, MASK, RESP} state_t;
  state_t           state_q;
  logic             last_q, id_q, dir_q;
  logic [WIDTH-1:0] data_q, result_q;
  logic [4:0]       amt_q;
  logic             g0, g1, sra;
  // req1 wins when it is the only requester, or on a tie when req0 was served last
  assign g1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign g0 = bus.req0_valid & ~g1;
  assign bus.req0_ready = (state_q == IDLE) & g0;
  assign bus.req1_ready = (state_q == IDLE) & g1;
  assign bus.rsp0_valid = (state_q == RESP) & ~id_q;
  assign bus.rsp1_valid = (state_q == RESP) & id_q;
  assign bus.rsp0_data  = result_q;
  assign bus.rsp1_data  = result_q;
  assign busy_o         = state_q != IDLE;
  // MASK pass shifts all-ones right by the same amount; its complement is the sign-fill mask
  assign sh_data_in_o   = state_q == SHIFT ? data_q : state_q == MASK ? '1 : '0;
  assign sh_amount_o    = (state_q == SHIFT || state_q == MASK) ? amt_q : 5'd0;
  assign sh_direction_o = state_q == SHIFT ? dir_q : state_q == MASK;
`ifdef SHIFTER_ARB_SRA_EN
  logic arith_q;
  assign sra = arith_q & dir_q & data_q[WIDTH-1] & (amt_q != 5'd0);
`else
  logic unused_arith;
  assign unused_arith = bus.req0_arith ^ bus.req1_arith;
  assign sra = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      dir_q    <= 1'b0;
      data_q   <= '0;
      amt_q    <= '0;
      result_q <= '0;
`ifdef SHIFTER_ARB_SRA_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (g0 | g1) begin
          data_q  <= g1 ? bus.req1_data : bus.req0_data;
          amt_q   <= g1 ? bus.req1_amount : bus.req0_amount;
          dir_q   <= g1 ? bus.req1_dir : bus.req0_dir;
          id_q    <= g1;
`ifdef SHIFTER_ARB_SRA_EN
          arith_q <= g1 ? bus.req1_arith : bus.req0_arith;
`endif
          state_q <= SHIFT;
        end
        SHIFT: begin
          result_q <= sh_data_out_i;
          state_q  <= sra ? MASK : RESP;
        end
        MASK: begin
          result_q <= result_q | ~sh_data_out_i;
          state_q  <= RESP;
        end
        default: if (id_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          last_q  <= id_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule
